// File: rtl/mac_seq_ctrl_if.sv
// Job request, operand-memory, MAC-datapath and result signals of mac_seq_ctrl.
// The master modport is the sequencer side; slave is the surrounding system.
interface mac_seq_ctrl_if #(
    parameter int unsigned A_BITWIDTH   = 8,
    parameter int unsigned B_BITWIDTH   = A_BITWIDTH,
    parameter int unsigned OUT_BITWIDTH = 20,
    parameter int unsigned C_BITWIDTH   = OUT_BITWIDTH - 1,
    parameter int unsigned ADDR_WIDTH   = 4
);
    logic                    start;
    logic [ADDR_WIDTH:0]     len;
    logic [C_BITWIDTH-1:0]   bias;
    logic                    busy;

    logic                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [A_BITWIDTH-1:0]   mem_a;
    logic [B_BITWIDTH-1:0]   mem_b;

    logic                    mac_en;
    logic                    mac_add;
    logic [A_BITWIDTH-1:0]   mac_a;
    logic [B_BITWIDTH-1:0]   mac_b;
    logic [C_BITWIDTH-1:0]   mac_c;
    logic                    mac_done;
    logic [OUT_BITWIDTH-1:0] mac_out;

    logic                    res_valid;
    logic                    res_ready;
    logic [OUT_BITWIDTH-1:0] res_data;
    logic                    ovf;

    modport master (
        input  start, len, bias, mem_a, mem_b, mac_done, mac_out, res_ready,
        output busy, mem_rd_en, mem_addr, mac_en, mac_add, mac_a, mac_b, mac_c,
               res_valid, res_data, ovf
    );

    modport slave (
        output start, len, bias, mem_a, mem_b, mac_done, mac_out, res_ready,
        input  busy, mem_rd_en, mem_addr, mac_en, mac_add, mac_a, mac_b, mac_c,
               res_valid, res_data, ovf
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product-plus-bias sequencer driving one shared MAC unit; each partial sum is
// fed back as the next accumulate input and the final sum leaves on a valid/ready port.
module mac_seq_ctrl #(
    parameter int unsigned A_BITWIDTH   = 8,
    parameter int unsigned B_BITWIDTH   = A_BITWIDTH,
    parameter int unsigned OUT_BITWIDTH = 20,
    parameter int unsigned C_BITWIDTH   = OUT_BITWIDTH - 1,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input logic            clk,
    input logic            rstn,
    mac_seq_ctrl_if.master bus
);
    localparam int unsigned HiW = OUT_BITWIDTH - C_BITWIDTH + 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StRelease,
        StResult
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [C_BITWIDTH-1:0]   bias_q, bias_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [OUT_BITWIDTH-1:0] acc_q, acc_d;
    logic [OUT_BITWIDTH-1:0] res_q, res_d;
    logic [A_BITWIDTH-1:0]   a_q, a_d;
    logic [B_BITWIDTH-1:0]   b_q, b_d;
    logic [C_BITWIDTH-1:0]   c_q, c_d;
    logic                    ovf_q, ovf_d;

    logic [ADDR_WIDTH:0]     len_m1;
    logic                    last_elem;
    logic [HiW-1:0]          hi_bits;
    logic                    fits_c;

    assign len_m1    = len_q - (ADDR_WIDTH + 1)'(1);
    assign last_elem = ({1'b0, idx_q} == len_m1);

    // Partial sum fits the accumulate input when bits [OUT-1:C-1] are all equal.
    assign hi_bits = bus.mac_out[OUT_BITWIDTH-1:C_BITWIDTH-1];
    assign fits_c  = (&hi_bits) | ~(|hi_bits);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bias_d  = bias_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d  = bus.len;
                    bias_d = bus.bias;
                    ovf_d  = 1'b0;
                    idx_d  = '0;
                    if (bus.len == '0) begin
                        res_d   = {{(OUT_BITWIDTH - C_BITWIDTH){bus.bias[C_BITWIDTH-1]}},
                                   bus.bias};
                        state_d = StResult;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                a_d     = bus.mem_a;
                b_d     = bus.mem_b;
                c_d     = (idx_q == '0) ? bias_q : acc_q[C_BITWIDTH-1:0];
                state_d = StIssue;
            end
            StIssue: begin
                if (bus.mac_done) begin
                    acc_d = bus.mac_out;
                    // The final sum is never fed back, so it is exempt from the fit check.
                    if (!last_elem && !fits_c) begin
                        ovf_d = 1'b1;
                    end
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!bus.mac_done) begin
                    if (last_elem) begin
                        res_d   = acc_q;
                        state_d = StResult;
                    end else begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = StFetch;
                    end
                end
            end
            StResult: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            len_q   <= '0;
            bias_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bias_q  <= bias_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.mem_rd_en = (state_q == StFetch);
    assign bus.mem_addr  = idx_q;
    assign bus.mac_en    = (state_q == StIssue);
    assign bus.mac_add   = 1'b0;
    assign bus.mac_a     = a_q;
    assign bus.mac_b     = b_q;
    assign bus.mac_c     = c_q;
    assign bus.res_valid = (state_q == StResult);
    assign bus.res_data  = res_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with behavioural operand memories and a
// multi-cycle MAC model whose done flag clears only after mac_en drops.
module tb_mac_seq_ctrl;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mac_seq_ctrl_if bus ();

    mac_seq_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] ma [16];
    logic [7:0] mb [16];
    int         mac_lat;

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_a <= ma[bus.mem_addr];
            bus.mem_b <= mb[bus.mem_addr];
        end
    end

    // MAC model: done after mac_lat+1 cycles, held until mac_en drops.
    int mac_cnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.mac_done <= 1'b0;
            bus.mac_out  <= '0;
            mac_cnt      <= 0;
        end else if (bus.mac_en && !bus.mac_done) begin
            if (mac_cnt >= mac_lat) begin
                bus.mac_done <= 1'b1;
                bus.mac_out  <= $signed(bus.mac_a) * $signed(bus.mac_b) + $signed(bus.mac_c);
                mac_cnt      <= 0;
            end else begin
                mac_cnt <= mac_cnt + 1;
            end
        end else if (!bus.mac_en) begin
            bus.mac_done <= 1'b0;
        end
    end

    // Monitor: pulse/read counts, accumulate-input sequence, operand stability.
    int          mac_pulses = 0;
    int          rd_cnt     = 0;
    int          viol       = 0;
    logic [3:0]  last_addr  = '0;
    logic        en_prev    = 1'b0;
    logic [34:0] ops_prev   = '0;
    logic [18:0] cq[$];
    always @(posedge clk) begin
        if (bus.mac_en && !en_prev) begin
            mac_pulses <= mac_pulses + 1;
            cq.push_back(bus.mac_c);
        end
        if (bus.mac_en && en_prev && ({bus.mac_a, bus.mac_b, bus.mac_c} != ops_prev)) begin
            viol <= viol + 1;
        end
        if (bus.mem_rd_en) begin
            rd_cnt    <= rd_cnt + 1;
            last_addr <= bus.mem_addr;
        end
        en_prev  <= bus.mac_en;
        ops_prev <= {bus.mac_a, bus.mac_b, bus.mac_c};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({bus.busy, bus.mem_rd_en, bus.mem_addr, bus.mac_en, bus.mac_add,
                                bus.res_valid, bus.ovf}), 64'd0);
        chk({tag, "_data"}, 64'({bus.mac_a, bus.mac_b, bus.mac_c, bus.res_data}), 64'd0);
    endtask

    task automatic start_job(input logic [4:0] l, input logic [18:0] bi);
        bus.len   = l;
        bus.bias  = bi;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!bus.res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(bus.res_valid), 64'd1);
    endtask

    task automatic finish_job(input string tag);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({tag, "_released"}, 64'(bus.res_valid), 64'd0);
    endtask

    int          p0, r0, q0, n;
    logic [19:0] held;

    initial begin
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bias      = '0;
        bus.res_ready = 1'b0;
        mac_lat       = 0;
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'd0;
            mb[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Job 1: 1*4 + 2*5 + 3*6 + 10 = 42
        ma[0] = 8'd1; ma[1] = 8'd2; ma[2] = 8'd3;
        mb[0] = 8'd4; mb[1] = 8'd5; mb[2] = 8'd6;
        p0 = mac_pulses; r0 = rd_cnt; q0 = cq.size();
        start_job(5'd3, 19'd10);
        chk("j1_busy", 64'(bus.busy), 64'd1);
        wait_result("j1");
        chk("j1_res", 64'(bus.res_data), 64'd42);
        chk("j1_ovf", 64'(bus.ovf), 64'd0);
        chk("j1_pulses", 64'(mac_pulses - p0), 64'd3);
        chk("j1_reads", 64'(rd_cnt - r0), 64'd3);
        chk("j1_c0", 64'(cq[q0]), 64'd10);
        chk("j1_c1", 64'(cq[q0+1]), 64'd14);
        chk("j1_c2", 64'(cq[q0+2]), 64'd24);
        finish_job("j1");
        chk("j1_idle", 64'(bus.busy), 64'd0);

        // Job 2: len=0 returns the sign-extended bias with no reads or MAC ops
        mac_lat = 1;
        p0 = mac_pulses; r0 = rd_cnt;
        start_job(5'd0, 19'h7FFFB);
        chk("j2_valid_next", 64'(bus.res_valid), 64'd1);
        chk("j2_res", 64'(bus.res_data), 64'hFFFFB);
        chk("j2_pulses", 64'(mac_pulses - p0), 64'd0);
        chk("j2_reads", 64'(rd_cnt - r0), 64'd0);
        finish_job("j2");

        // Job 3: (-128)*(-128) = 16384
        ma[0] = 8'h80; mb[0] = 8'h80;
        start_job(5'd1, 19'd0);
        wait_result("j3");
        chk("j3_res", 64'(bus.res_data), 64'd16384);
        finish_job("j3");

        // Job 4: 16 * 16384 = 262144; final sum exempt from the fit check
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'h80;
            mb[i] = 8'h80;
        end
        p0 = mac_pulses; r0 = rd_cnt;
        start_job(5'd16, 19'd0);
        wait_result("j4");
        chk("j4_res", 64'(bus.res_data), 64'h40000);
        chk("j4_ovf", 64'(bus.ovf), 64'd0);
        chk("j4_pulses", 64'(mac_pulses - p0), 64'd16);
        chk("j4_last_addr", 64'(last_addr), 64'd15);
        finish_job("j4");

        // Job 5: 262143 + 1 overflows the 19-bit feedback, wraps to -262144
        mac_lat = 3;
        ma[0] = 8'd1; ma[1] = 8'd1;
        mb[0] = 8'd1; mb[1] = 8'd1;
        q0 = cq.size();
        start_job(5'd2, 19'd262143);
        wait_result("j5");
        chk("j5_ovf", 64'(bus.ovf), 64'd1);
        chk("j5_c1", 64'(cq[q0+1]), 64'h40000);
        chk("j5_res", 64'(bus.res_data), 64'hC0001);

        // Result held under back-pressure; start ignored in RESULT
        held = bus.res_data;
        for (int i = 0; i < 5; i++) begin
            bus.start = ~bus.start;
            bus.len   = 5'd1;
            @(negedge clk);
            chk("hold_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_data", 64'(bus.res_data), 64'(held));
        end
        ma[0] = 8'd5; mb[0] = 8'hFD;
        bus.len       = 5'd1;
        bus.bias      = 19'd0;
        bus.start     = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("hs_valid", 64'(bus.res_valid), 64'd0);
        chk("hs_start_ignored", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("next_start_accepted", 64'(bus.busy), 64'd1);
        wait_result("j6");
        chk("j6_res", 64'(bus.res_data), 64'hFFFF1);
        finish_job("j6");

        // Reset during ISSUE of element 1 of 3
        mac_lat = 4;
        ma[0] = 8'd1; ma[1] = 8'd1; ma[2] = 8'd1;
        mb[0] = 8'd1; mb[1] = 8'd1; mb[2] = 8'd1;
        start_job(5'd3, 19'd0);
        n = 0;
        while (!(bus.mac_en && bus.mem_addr == 4'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_issue1", 64'(bus.mac_en), 64'd1);
        rstn = 1'b0;
        #1;
        chk_all_zero("midjob_rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_rst_idle", 64'({bus.busy, bus.res_valid}), 64'd0);

        // Fresh job after reset: 2*3 + 1 = 7
        mac_lat = 1;
        ma[0] = 8'd2; mb[0] = 8'd3;
        start_job(5'd1, 19'd1);
        wait_result("j7");
        chk("j7_res", 64'(bus.res_data), 64'd7);
        chk("j7_ovf", 64'(bus.ovf), 64'd0);
        finish_job("j7");

        chk("mac_ops_stable", 64'(viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that computes a signed dot product plus bias on a single shared MAC unit: res = bias + sum(a[i]*b[i]) for i = 0..len-1.
- Reads operand pairs from two synchronous-read operand memories that share one address, issues one MAC operation per element, and feeds each partial sum back as the next accumulate input.
- Returns the final sum on a valid/ready result port.
- Sits between the layer-level control FSM and the MAC datapath.

Parameters:
- A_BITWIDTH, 8, width of operand a (signed).
- B_BITWIDTH, A_BITWIDTH, width of operand b (signed).
- OUT_BITWIDTH, 20, MAC result width (signed).
- C_BITWIDTH, OUT_BITWIDTH-1, MAC accumulate-input width (signed).
- ADDR_WIDTH, 4, operand memory address width; maximum len = 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- len  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH; captured on start.
- bias  in  C_BITWIDTH  signed initial accumulate value; captured on start.
- busy  out  1  high in every state except IDLE.
- mem_rd_en  out  1  read strobe to both operand memories.
- mem_addr  out  ADDR_WIDTH  element index.
- mem_a  in  A_BITWIDTH  read data; valid exactly 1 cycle after mem_rd_en.
- mem_b  in  B_BITWIDTH  read data; valid exactly 1 cycle after mem_rd_en.
- mac_en  out  1  MAC operation request.
- mac_add  out  1  MAC mode select; this block always drives 0 (multiply-accumulate).
- mac_a  out  A_BITWIDTH  registered MAC operand a.
- mac_b  out  B_BITWIDTH  registered MAC operand b.
- mac_c  out  C_BITWIDTH  registered MAC accumulate input.
- mac_done  in  1  MAC completion flag.
- mac_out  in  OUT_BITWIDTH  MAC result; valid while mac_done=1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  OUT_BITWIDTH  signed result.
- ovf  out  1  sticky: an intermediate partial sum did not fit in C_BITWIDTH signed.

Behaviour:
- Reset: state=IDLE. All outputs are 0: busy, mem_rd_en, mem_addr, mac_en, mac_add, mac_a, mac_b, mac_c, res_valid, res_data, ovf. Internal index and accumulator are 0.
- Reset mid-job: abort immediately and drop mac_en. No result is produced. The MAC is reset by the same rstn.
- States: IDLE, FETCH, LOAD, ISSUE, RELEASE, RESULT.
- IDLE:
  - start=1 captures len, bias; clears ovf; sets idx=0.
  - If len=0: go to RESULT with res_data = sign-extended bias. No memory reads, no MAC operations.
  - Otherwise go to FETCH.
- FETCH (1 cycle): mem_rd_en=1, mem_addr=idx. Go to LOAD.
- LOAD (1 cycle):
  - Register mac_a<=mem_a, mac_b<=mem_b.
  - mac_c <= bias if idx=0, else acc[C_BITWIDTH-1:0] (low bits, two's-complement wrap).
  - Go to ISSUE.
- ISSUE:
  - mac_en=1; mac_a, mac_b, mac_c held stable.
  - On mac_done=1: acc<=mac_out.
  - If idx != len-1 and mac_out does not fit in C_BITWIDTH signed (mac_out[OUT-1] != mac_out[OUT-2] when C=OUT-1; general rule: upper bits not all equal to bit C-1), set ovf.
  - Go to RELEASE.
- RELEASE:
  - mac_en=0. Wait until mac_done=0, minimum 1 cycle, no timeout.
  - Then, if idx=len-1: res_data<=acc, go to RESULT.
  - Else idx<=idx+1, go to FETCH.
- RESULT:
  - res_valid=1; res_data and ovf held stable.
  - On res_ready=1 (same cycle): res_valid<=0, go to IDLE.
  - start is ignored in every non-IDLE state, including RESULT. A start in the same cycle as the res_ready handshake is also ignored; it is accepted from the next IDLE cycle.
- Never assert mac_en while mac_done=1. Never change mac_a, mac_b or mac_c while mac_en=1.
- Per-element latency: 2 cycles + MAC latency + release wait. len=2^ADDR_WIDTH: idx wraps neither memory address nor count (idx max = len-1).
- mac_done asserted outside ISSUE or RELEASE is ignored.

Test Plan:
- len=3, a={1,2,3}, b={4,5,6}, bias=10 -> exactly 3 mac_en pulses; mac_c sequence 10,14,24; res_data=42, ovf=0.
- len=0, bias=-5 -> no mem_rd_en, no mac_en; res_valid next cycle with res_data=20'hFFFFB.
- len=1, a={-128}, b={-128}, bias=0 -> res_data=16384. len=16, all a=b=-128 -> res_data=262144, ovf=0 (final value is exempt from the fit check).
- len=2, a=b={1,1}, bias=262143 -> ovf=1; second mac_c=-262144; res_data=-262143 (20'hC0001).
- res_ready held 0 for 5 cycles with start pulsing -> res_valid and res_data stable, start ignored; res_ready=1 -> res_valid=0 next cycle, then a new start is accepted.
- rstn low during ISSUE of element 1 of 3 -> all outputs 0 asynchronously. After release, a fresh job with len=1, a=2, b=3, bias=1 -> res_data=7.
